sparse_idx_sched: RTL and testbench

- Upstream feeder for the sparse polynomial multiplier core.
- On a load request it unpacks NUM_IDX sparse-term indices from the 128-bit key word.
- It emits them one per handshake on a valid/ready stream, interleaved with exactly NUM_DUMMY LFSR-chosen dummy slots.
- Every operation therefore takes a constant NUM_IDX+NUM_DUMMY slots; the multiplier executes dummy slots without accumulating them.

---
 rtl/sparse_pkg.sv | 31 +++
 rtl/sparse_lfsr.sv | 26 ++
 rtl/sparse_idx_sched.sv | 133 +++++++++++++
 tb/tb_sparse_idx_sched.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sparse_pkg.sv
// Shared parameters, state encoding, slot record and LFSR step for the sparse index scheduler.
package sparse_pkg;

  localparam int IDX_W     = 8;
  localparam int NUM_IDX   = 16;
  localparam int NUM_DUMMY = 8;
  localparam int LFSR_W    = 16;
  localparam int KEY_W     = IDX_W * NUM_IDX;
  localparam int CNT_W     = $clog2(NUM_IDX + NUM_DUMMY + 1);

  localparam logic [LFSR_W-1:0] SEED      = 16'hACE1;
  // Taps for x^16+x^14+x^13+x^11+1 on a left-shifting Fibonacci register
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             dummy;
  } slot_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sparse_lfsr.sv
// Fibonacci LFSR with step and load enables; also used by the multiplier core's masking.
module sparse_lfsr
  import sparse_pkg::*;
#(
  parameter logic [LFSR_W-1:0] INIT = SEED
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              step_en,
  input  logic              load_en,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);

  // A zero load would lock the register, so it is refused here as well.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= INIT;
    end else if (load_en && (load_val != '0)) begin
      state <= load_val;
    end else if (step_en) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/sparse_idx_sched.sv
// Sparse index scheduler: streams NUM_IDX key indices mixed with LFSR-placed dummy slots.
// Dummy insertion is built only when SPARSE_DUMMY_INSERT_EN is defined.
module sparse_idx_sched
  import sparse_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_i,
  input  logic [KEY_W-1:0]  key_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              dummy_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o
);

`ifdef SPARSE_DUMMY_INSERT_EN
  localparam int DUMMIES = NUM_DUMMY;
`else
  localparam int DUMMIES = 0;
`endif

  state_t           state;
  logic [KEY_W-1:0] key_sr;
  logic [CNT_W-1:0] real_cnt;
  logic [CNT_W-1:0] dum_cnt;
  logic             accept;
  logic             hs;
  logic             last;
  logic             compute;
  slot_t            slot_nxt;

  // Counters hold the slots not yet issued, so the displayed slot is already deducted.
  assign accept  = (state == IDLE) && load_i;
  assign hs      = valid_o && ready_i;
  assign last    = hs && (real_cnt == '0) && (dum_cnt == '0);
  assign compute = (state == PREP) || (hs && !last);

`ifdef SPARSE_DUMMY_INSERT_EN
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_dec;
  logic              unused_lfsr_hi;

  sparse_lfsr #(.INIT(SEED)) u_lfsr (
    .clk      (clk),
    .resetn   (resetn),
    .step_en  (hs),
    .load_en  (accept && (seed_i != '0)),
    .load_val (seed_i),
    .state    (lfsr)
  );

  // A slot computed on a handshake sees the value the LFSR steps to on that edge.
  assign lfsr_dec       = (state == PREP) ? lfsr : lfsr_step(lfsr);
  assign unused_lfsr_hi = ^lfsr_dec[LFSR_W-1:IDX_W+1];

  always_comb begin
    slot_nxt.dummy = (real_cnt == '0) || ((dum_cnt != '0) && lfsr_dec[0]);
    slot_nxt.idx   = slot_nxt.dummy ? lfsr_dec[IDX_W:1] : key_sr[IDX_W-1:0];
  end
`else
  logic unused_seed;
  assign unused_seed = ^seed_i;

  always_comb begin
    slot_nxt.dummy = 1'b0;
    slot_nxt.idx   = key_sr[IDX_W-1:0];
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      real_cnt <= '0;
      dum_cnt  <= '0;
      idx_o    <= '0;
      dummy_o  <= 1'b0;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (load_i) begin
            state    <= PREP;
            real_cnt <= CNT_W'(NUM_IDX);
            dum_cnt  <= CNT_W'(DUMMIES);
            busy_o   <= 1'b1;
          end
        end
        PREP: begin
          state   <= EMIT;
          valid_o <= 1'b1;
        end
        EMIT: begin
          if (last) begin
            state   <= DONE;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          done_o <= 1'b0;
        end
      endcase

      if (compute) begin
        idx_o   <= slot_nxt.idx;
        dummy_o <= slot_nxt.dummy;
        if (slot_nxt.dummy) begin
          dum_cnt <= dum_cnt - 1'b1;
        end else begin
          real_cnt <= real_cnt - 1'b1;
        end
      end
    end
  end

  // Key shift register carries data only and needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      key_sr <= key_i;
    end else if (compute && !slot_nxt.dummy) begin
      key_sr <= key_sr >> IDX_W;
    end
  end

endmodule

// File: tb/tb_sparse_idx_sched.sv
// Directed bench for sparse_idx_sched; honours SPARSE_DUMMY_INSERT_EN like the design.
module tb_sparse_idx_sched;

`ifdef SPARSE_DUMMY_INSERT_EN
  localparam int NDUM = 8;
`else
  localparam int NDUM = 0;
`endif
  localparam int NTOT = 16 + NDUM;
  localparam logic [127:0] K0 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] K1 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

  logic         clk = 1'b0;
  logic         resetn;
  logic         load_i;
  logic [127:0] key_i;
  logic [15:0]  seed_i;
  logic [7:0]   idx_o;
  logic         dummy_o;
  logic         valid_o;
  logic         ready_i;
  logic         busy_o;
  logic         done_o;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [15:0]  m_lfsr;
  logic [7:0]   exp_idx [24];
  logic         exp_dum [24];
  logic [23:0]  last_mask;
  logic [23:0]  mask_a, mask_b, mask_c;

  always #5 clk = ~clk;

  sparse_idx_sched dut (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (load_i),
    .key_i   (key_i),
    .seed_i  (seed_i),
    .idx_o   (idx_o),
    .dummy_o (dummy_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic build_exp(input logic [127:0] key, input logic [15:0] seed);
    int r, d, k;
    logic [15:0] l;
    if (seed != 16'h0) m_lfsr = seed;
    l = m_lfsr; r = 16; d = NDUM; k = 0;
    for (int i = 0; i < NTOT; i++) begin
      if (r == 0 || (d != 0 && l[0])) begin
        exp_dum[i] = 1'b1; exp_idx[i] = l[8:1]; d--;
      end else begin
        exp_dum[i] = 1'b0; exp_idx[i] = key[k*8 +: 8]; k++; r--;
      end
      l = ref_step(l);
    end
    m_lfsr = l;
  endtask

  task automatic run_op(input logic [127:0] key, input logic [15:0] seed,
                        input bit toggle, input bit poke, input int abort_at);
    int n;
    bit done_seen, busy_ok, have_hold;
    logic [7:0] hold_idx;
    logic hold_dum;
    build_exp(key, seed);
    @(negedge clk);
    load_i = 1'b1; key_i = key; seed_i = seed; ready_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    chk("prep_valid", valid_o, 0);
    chk("prep_busy", busy_o, 1);
    @(negedge clk);
    chk("latency_valid", valid_o, 1);
    n = 0; done_seen = 0; busy_ok = 1; have_hold = 0; last_mask = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) @(negedge clk);
      load_i = poke && (cyc == 4);
      if (poke && cyc == 4) key_i = ~key;
      if (done_o) begin done_seen = 1; break; end
      if (!busy_o) busy_ok = 0;
      ready_i = toggle ? (cyc % 2 == 0) : 1'b1;
      if (have_hold) begin
        chk("stall_idx", idx_o, hold_idx);
        chk("stall_dummy", dummy_o, hold_dum);
        have_hold = 0;
      end
      if (valid_o && ready_i) begin
        if (n < NTOT) begin
          chk($sformatf("slot%0d_idx", n), idx_o, exp_idx[n]);
          chk($sformatf("slot%0d_dummy", n), dummy_o, exp_dum[n]);
          last_mask[n] = dummy_o;
        end
        n++;
        if (abort_at != 0 && n == abort_at) begin
          @(posedge clk);
          #1 resetn = 1'b0;
          #1;
          chk("abort_idx", idx_o, 0);
          chk("abort_dummy", dummy_o, 0);
          chk("abort_valid", valid_o, 0);
          chk("abort_busy", busy_o, 0);
          chk("abort_done", done_o, 0);
          m_lfsr = 16'hACE1;
          load_i = 1'b0; ready_i = 1'b0;
          repeat (3) @(negedge clk);
          chk("abort_no_done", done_o, 0);
          resetn = 1'b1;
          return;
        end
      end else if (valid_o) begin
        have_hold = 1; hold_idx = idx_o; hold_dum = dummy_o;
      end
    end
    load_i = 1'b0;
    chk("done_seen", done_seen, 1);
    chk("slot_count", n, NTOT);
    chk("busy_held", busy_ok, 1);
    chk("done_busy_low", busy_o, 0);
    chk("done_valid_low", valid_o, 0);
    @(negedge clk);
    chk("done_pulse", done_o, 0);
    ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; load_i = 1'b0; key_i = '0; seed_i = '0; ready_i = 1'b0;
    m_lfsr = 16'hACE1;
    repeat (2) @(negedge clk);
    chk("rst_idx", idx_o, 0);
    chk("rst_dummy", dummy_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    resetn = 1'b1;

    // continuous ready from the reset seed, then the same stream under a stalling consumer
    run_op(K0, 16'h0000, 1'b0, 1'b0, 0);
    mask_a = last_mask;
    run_op(K0, 16'hACE1, 1'b1, 1'b0, 0);
    chk("toggle_same_pattern", last_mask, mask_a);

    // explicit reseed reproduces the pattern; a zero seed continues the sequence
    run_op(K1, 16'h0001, 1'b0, 1'b0, 0);
    mask_a = last_mask;
    run_op(K1, 16'h0001, 1'b0, 1'b0, 0);
    mask_b = last_mask;
    chk("reseed_repeat", mask_b, mask_a);
    run_op(K1, 16'h0000, 1'b0, 1'b0, 0);
    mask_c = last_mask;
`ifdef SPARSE_DUMMY_INSERT_EN
    chk("reseed0_differs", mask_c != mask_a, 1);
`endif

    // load pulse while emitting must be ignored
    run_op(K0, 16'h0000, 1'b0, 1'b1, 0);

    // reset after the fifth handshake, then a clean full run
    run_op(K0, 16'h0000, 1'b0, 1'b0, 5);
    run_op(K0, 16'h0000, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
